fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter and drives a synchronous instruction ROM.
- Holds the fetched word in a decode register that feeds the control decoder's instr input, together with its PC and a valid flag.
- Handles program start and done, stall freeze, taken-branch redirect with squash, and halt.

Parameters:
- PC_WIDTH, 10, width of PC and ROM address; PC wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 9, instruction word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution at start_addr.
- start_addr  input  PC_WIDTH  first fetch address.
- stall  input  1  freezes the fetch stage and the decode register.
- branch_taken  input  1  redirect request for the instruction currently in the decode register.
- branch_target  input  PC_WIDTH  redirect address.
- halt_req  input  1  decoder flags the current decode instruction as halt.
- imem_addr  output  PC_WIDTH  ROM read address (combinational).
- imem_rdata  input  INSTR_WIDTH  ROM data; equals mem[address presented in the previous cycle].
- instr  output  INSTR_WIDTH  decode register word, to the control decoder.
- instr_pc  output  PC_WIDTH  address of instr.
- instr_valid  output  1  instr is a real, non-squashed instruction.
- done  output  1  high while in HALT.

Behaviour:
- States: IDLE, RUN, HALT.
- Registers: pc (next fetch address), pc_prev (address issued last cycle), pend (a read was issued last cycle), plus the decode register (instr, instr_pc, instr_valid).
- Reset (async, any state, including mid-run):
  - state=IDLE; pc, pc_prev, instr, instr_pc = 0.
  - pend, instr_valid, done = 0.
- imem_addr mux, priority order:
  - stall=1 in RUN -> pc_prev (re-reads the in-flight address, so imem_rdata stays stable).
  - else branch_taken=1 in RUN -> branch_target.
  - else -> pc.
- IDLE:
  - instr_valid=0, done=0.
  - start=1 -> pc<=start_addr, pend<=0, go to RUN.
- RUN, stall=1:
  - All registers hold.
  - branch_taken and halt_req are ignored; the decoder must hold them until stall drops.
- RUN, stall=0, normal cycle:
  - instr<=imem_rdata, instr_pc<=pc_prev, instr_valid<=pend.
  - pc_prev<=pc, pc<=pc+1 (wraps at max to 0), pend<=1.
- RUN, stall=0, branch_taken=1 and instr_valid=1:
  - instr_valid<=0 (squashes the wrong-path word).
  - pc_prev<=branch_target, pc<=branch_target+1, pend<=1.
  - Exactly one bubble cycle; the target word is valid 2 cycles after the branch cycle.
- RUN, stall=0, halt_req=1 and instr_valid=1:
  - Go to HALT; instr_valid<=0, pend<=0, done<=1; pc frozen.
  - halt_req has priority over branch_taken when both are high.
- branch_taken or halt_req with instr_valid=0: ignored.
- start while in RUN: ignored.
- HALT:
  - done=1, instr_valid=0.
  - start=1 -> done<=0, pc<=start_addr, pend<=0, go to RUN (restart).
- Start latency: start in cycle S -> imem_addr=start_addr in S+1 -> first instr_valid=1 visible in S+3.
- In steady RUN with no stalls: one instr_valid per cycle, instr_pc incrementing by 1.

Test Plan:
(Setup for all: PC_WIDTH=8; ROM mem[i]=i+0x100.)
- Reset, start=1 with start_addr=0x10 in cycle 0:
  - instr_valid first high in cycle 3 with instr=0x110, instr_pc=0x10.
  - Then 0x111, 0x112 on consecutive cycles.
- Stall held 3 cycles while instr=0x112 is showing:
  - instr, instr_pc, instr_valid frozen for those cycles; imem_addr=pc_prev.
  - After release, next instr=0x113 with no word lost or duplicated.
- branch_taken=1, branch_target=0x40 while instr_pc=0x20:
  - Next cycle instr_valid=0.
  - The cycle after: instr=0x140, instr_pc=0x40, then 0x141.
- halt_req and branch_taken both high with instr_valid=1:
  - done=1 next cycle, instr_valid=0, stays halted.
  - start with start_addr=0x05 -> done=0, instr=0x105 valid 3 cycles later.
- Start at 0xFE:
  - instr_pc sequence 0xFE, 0xFF, 0x00, 0x01 (wrap), instr=0x1FE, 0x1FF, 0x100, 0x101.
- reset asserted mid-RUN between clock edges:
  - Outputs clear immediately (instr_valid=0, done=0, instr=0, instr_pc=0), state IDLE.
  - No fetch activity until the next start pulse.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, synchronous ROM interface and decode register.
// Handles start/restart, stall freeze, branch redirect with one-bubble squash, and halt.
module fetch_unit #(
   parameter int PC_WIDTH    = 10,
   parameter int INSTR_WIDTH = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [PC_WIDTH-1:0]    start_addr,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   input  logic                   halt_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    instr_pc,
   output logic                   instr_valid,
   output logic                   done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

   state_t              state;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_prev;
   logic                pend;
   logic                run;

   assign run = (state == RUN);

   // Re-reading pc_prev while stalled keeps imem_rdata pinned to the in-flight word.
   always_comb begin
      imem_addr = pc;
      if (run && stall) begin
         imem_addr = pc_prev;
      end else if (run && branch_taken && instr_valid) begin
         imem_addr = branch_target;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= '0;
         pc_prev     <= '0;
         pend        <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               instr_valid <= 1'b0;
               done        <= 1'b0;
               if (start) begin
                  pc    <= start_addr;
                  pend  <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (halt_req && instr_valid) begin
                     state       <= HALT;
                     instr_valid <= 1'b0;
                     pend        <= 1'b0;
                     done        <= 1'b1;
                  end else if (branch_taken && instr_valid) begin
                     // The word arriving now is wrong-path; the target read is issued this cycle.
                     instr_valid <= 1'b0;
                     pc_prev     <= branch_target;
                     pc          <= branch_target + PC_ONE;
                     pend        <= 1'b1;
                  end else begin
                     instr       <= imem_rdata;
                     instr_pc    <= pc_prev;
                     instr_valid <= pend;
                     pc_prev     <= pc;
                     pc          <= pc + PC_ONE;
                     pend        <= 1'b1;
                  end
               end
            end
            HALT: begin
               done        <= 1'b1;
               instr_valid <= 1'b0;
               if (start) begin
                  done  <= 1'b0;
                  pc    <= start_addr;
                  pend  <= 1'b0;
                  state <= RUN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing checks plus randomized programs whose
// expected instruction stream comes from a program-flow model and a scoreboard.
module tb_fetch_unit;

   localparam int PW = 8;
   localparam int IW = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [PW-1:0] start_addr;
   logic          stall;
   logic          branch_taken;
   logic [PW-1:0] branch_target;
   logic          halt_req;
   logic [PW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic [IW-1:0] instr;
   logic [PW-1:0] instr_pc;
   logic          instr_valid;
   logic          done;

   logic [IW-1:0] mem [256];
   bit            br_en [256];
   int            br_tgt [256];
   int            exp_q [$];
   int            errors = 0;
   int            checks = 0;

   fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .start_addr(start_addr),
      .stall(stall),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .halt_req(halt_req),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_valid(instr_valid),
      .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= mem[imem_addr];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Program flow: sequential addresses mod 256, jumping at branch sites, k words total.
   function automatic void push_stream(input int a, input int k);
      int p;
      p = a;
      for (int i = 0; i < k; i++) begin
         exp_q.push_back(p);
         if (i < k - 1 && br_en[p]) p = br_tgt[p];
         else p = (p + 1) % 256;
      end
   endfunction

   // Scoreboard monitor: every word the decoder accepts must be next in program order.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got pc %0h, none expected", instr_pc);
            end else begin
               e = exp_q.pop_front();
               check("stream_pc", int'(instr_pc), e);
               check("stream_instr", int'(instr), 'h100 + e);
            end
         end
      end
   end

   task automatic pulse_start(input int a);
      @(negedge clk);
      start      = 1'b1;
      start_addr = PW'(a);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_prog(input int a, input int k);
      int  ncons;
      bit  halted;
      bit  fin;
      ncons  = 0;
      halted = 0;
      fin    = 0;
      for (int i = 0; i < 256; i++) begin
         br_en[i]  = ($urandom_range(0, 5) == 0);
         br_tgt[i] = $urandom_range(0, 255);
      end
      push_stream(a, k);
      @(negedge clk);
      start      = 1'b1;
      start_addr = PW'(a);
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (halted) begin
            branch_taken = 1'b0;
            halt_req     = 1'b0;
            stall        = 1'b0;
            check("rand_done", int'(done), 1);
            check("rand_halt_valid", int'(instr_valid), 0);
            fin = 1;
         end else begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = instr_valid && br_en[instr_pc];
            branch_target = PW'(br_tgt[instr_pc]);
            halt_req      = instr_valid && (ncons == k - 1);
            if (instr_valid && !stall) begin
               ncons++;
               if (halt_req) halted = 1;
            end
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL rand_timeout: got %0d words want %0d", ncons, k);
      end
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]   = IW'('h100 + i);
         br_en[i] = 0;
      end
      reset         = 1'b1;
      start         = 1'b0;
      start_addr    = '0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      halt_req      = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", int'(instr_valid), 0);
      check("rst_done", int'(done), 0);
      check("rst_instr", int'(instr), 0);
      check("rst_pc", int'(instr_pc), 0);
      reset = 1'b0;

      // start 0x10, stall on 0x112, branch 0x20 -> 0x40, halt+branch on 0x42
      for (int p = 'h10; p <= 'h20; p++) exp_q.push_back(p);
      exp_q.push_back('h40);
      exp_q.push_back('h41);
      exp_q.push_back('h42);
      pulse_start('h10);
      #1 check("start_addr_out", int'(imem_addr), 'h10);
      check("start_n1_valid", int'(instr_valid), 0);
      @(negedge clk);
      check("start_n2_valid", int'(instr_valid), 0);
      @(negedge clk);
      check("first_valid", int'(instr_valid), 1);
      check("first_instr", int'(instr), 'h110);
      check("first_pc", int'(instr_pc), 'h10);
      @(negedge clk);
      check("second_instr", int'(instr), 'h111);
      @(negedge clk);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_instr", int'(instr), 'h112);
         check("stall_pc", int'(instr_pc), 'h12);
         check("stall_valid", int'(instr_valid), 1);
         check("stall_addr", int'(imem_addr), 'h13);
         @(negedge clk);
      end
      stall = 1'b0;
      check("post_stall_hold", int'(instr), 'h112);
      @(negedge clk);
      check("post_stall_next", int'(instr), 'h113);
      for (int i = 0; i < 40 && instr_pc != PW'('h20); i++) @(negedge clk);
      check("reach_20", int'(instr_pc), 'h20);
      branch_taken  = 1'b1;
      branch_target = PW'('h40);
      #1 check("branch_addr", int'(imem_addr), 'h40);
      @(negedge clk);
      branch_taken = 1'b0;
      check("bubble", int'(instr_valid), 0);
      @(negedge clk);
      check("tgt_valid", int'(instr_valid), 1);
      check("tgt_instr", int'(instr), 'h140);
      check("tgt_pc", int'(instr_pc), 'h40);
      @(negedge clk);
      check("tgt_next", int'(instr), 'h141);
      @(negedge clk);
      check("pre_halt", int'(instr), 'h142);
      halt_req      = 1'b1;
      branch_taken  = 1'b1;
      branch_target = PW'('h77);
      @(negedge clk);
      halt_req     = 1'b0;
      branch_taken = 1'b0;
      check("halt_done", int'(done), 1);
      check("halt_valid", int'(instr_valid), 0);
      repeat (3) @(negedge clk);
      check("halt_stays", int'(done), 1);
      check("halt_stays_valid", int'(instr_valid), 0);
      check("dir_drained", exp_q.size(), 0);

      // restart from HALT, then reset between edges
      exp_q.push_back('h05);
      exp_q.push_back('h06);
      exp_q.push_back('h07);
      pulse_start('h05);
      check("restart_done", int'(done), 0);
      repeat (2) @(negedge clk);
      check("restart_instr", int'(instr), 'h105);
      check("restart_valid", int'(instr_valid), 1);
      repeat (2) @(negedge clk);
      #3 reset = 1'b1;
      #1;
      check("async_valid", int'(instr_valid), 0);
      check("async_done", int'(done), 0);
      check("async_instr", int'(instr), 0);
      check("async_pc", int'(instr_pc), 0);
      check("restart_drained", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("idle_valid", int'(instr_valid), 0);
         check("idle_addr", int'(imem_addr), 0);
      end

      // wrap at the top of the address space
      exp_q.push_back('hFE);
      exp_q.push_back('hFF);
      exp_q.push_back('h00);
      exp_q.push_back('h01);
      pulse_start('hFE);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("wrap_pc", int'(instr_pc), ('hFE + i) % 256);
         check("wrap_instr", int'(instr), 'h100 + (('hFE + i) % 256));
      end
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      check("wrap_halt", int'(done), 1);
      check("wrap_drained", exp_q.size(), 0);
      exp_q.delete();

      for (int r = 0; r < 25; r++) begin
         run_prog($urandom_range(0, 255), $urandom_range(3, 30));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
